i2c_target: RTL and testbench

- I2C target (responder) for the bus our I2C_clk_div-driven initiator masters; 7-bit addressing, write and read transfers.
- Oversamples externally driven SCL/SDA on ref_clk, detects START/STOP, matches address, ACKs.
- Delivers received bytes to the fabric and serves read bytes from the fabric.
- Open-drain SDA: block only requests pull-low via sda_oe; pad logic is outside.

---
 rtl/i2c_target.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with 7-bit addressing: oversampled, glitch-filtered SCL/SDA,
// START/STOP detection, address match, write delivery and read service.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       ref_clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    localparam logic [2:0] FILT_LAST = 3'(FILTER_LEN - 1);

    logic [1:0] r_sclSync, r_sdaSync;
    logic [2:0] r_sclCnt, r_sdaCnt;
    logic       r_sclFilt, r_sdaFilt, r_sclPrev, r_sdaPrev;

    state_t     r_state, w_state;
    logic [2:0] r_bitCnt, w_bitCnt;
    logic [7:0] r_shift, w_shift;
    logic [7:0] r_txShift, w_txShift;
    logic       r_byteDone, w_byteDone;
    logic       r_rxPending, w_rxPending;
    logic       r_sdaOe, w_sdaOe;
    logic       r_busy, w_busy;
    logic [7:0] r_rxData, w_rxData;
    logic       r_rxValid, w_rxValid;
    logic       r_rxFirst, w_rxFirst;
    logic       w_txReq;

    logic w_sclRise, w_sclFall, w_start, w_stop;

    // A line only takes a new level after FILTER_LEN consecutive differing samples.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclSync <= 2'b11;
            r_sdaSync <= 2'b11;
            r_sclCnt  <= '0;
            r_sdaCnt  <= '0;
            r_sclFilt <= 1'b1;
            r_sdaFilt <= 1'b1;
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[0], scl_in};
            r_sdaSync <= {r_sdaSync[0], sda_in};
            if (r_sclSync[1] == r_sclFilt) begin
                r_sclCnt <= '0;
            end else if (r_sclCnt == FILT_LAST) begin
                r_sclFilt <= r_sclSync[1];
                r_sclCnt  <= '0;
            end else begin
                r_sclCnt <= r_sclCnt + 3'd1;
            end
            if (r_sdaSync[1] == r_sdaFilt) begin
                r_sdaCnt <= '0;
            end else if (r_sdaCnt == FILT_LAST) begin
                r_sdaFilt <= r_sdaSync[1];
                r_sdaCnt  <= '0;
            end else begin
                r_sdaCnt <= r_sdaCnt + 3'd1;
            end
            r_sclPrev <= r_sclFilt;
            r_sdaPrev <= r_sdaFilt;
        end
    end

    assign w_sclRise = r_sclFilt & ~r_sclPrev;
    assign w_sclFall = ~r_sclFilt & r_sclPrev;
    assign w_start   = r_sclFilt & r_sclPrev & r_sdaPrev & ~r_sdaFilt;
    assign w_stop    = r_sclFilt & r_sclPrev & ~r_sdaPrev & r_sdaFilt;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_txShift   <= '0;
            r_byteDone  <= 1'b0;
            r_rxPending <= 1'b0;
            r_sdaOe     <= 1'b0;
            r_busy      <= 1'b0;
            r_rxData    <= '0;
            r_rxValid   <= 1'b0;
            r_rxFirst   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bitCnt    <= w_bitCnt;
            r_shift     <= w_shift;
            r_txShift   <= w_txShift;
            r_byteDone  <= w_byteDone;
            r_rxPending <= w_rxPending;
            r_sdaOe     <= w_sdaOe;
            r_busy      <= w_busy;
            r_rxData    <= w_rxData;
            r_rxValid   <= w_rxValid;
            r_rxFirst   <= w_rxFirst;
        end
    end

    // START/STOP take priority over any SCL edge seen in the same cycle.
    always_comb begin
        w_state     = r_state;
        w_bitCnt    = r_bitCnt;
        w_shift     = r_shift;
        w_txShift   = r_txShift;
        w_byteDone  = r_byteDone;
        w_rxPending = r_rxPending;
        w_sdaOe     = r_sdaOe;
        w_busy      = r_busy;
        w_rxData    = r_rxData;
        w_rxValid   = 1'b0;
        w_rxFirst   = 1'b0;
        w_txReq     = 1'b0;
        if (w_start) begin
            w_state     = ADDR;
            w_bitCnt    = '0;
            w_byteDone  = 1'b0;
            w_rxPending = 1'b0;
            w_sdaOe     = 1'b0;
            w_busy      = 1'b1;
        end else if (w_stop) begin
            w_state = IDLE;
            w_sdaOe = 1'b0;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_sclRise) begin
                        w_shift  = {r_shift[6:0], r_sdaFilt};
                        w_bitCnt = r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) w_byteDone = 1'b1;
                    end else if (w_sclFall && r_byteDone) begin
                        w_byteDone = 1'b0;
                        if (r_shift[7:1] == TARGET_ADDR) begin
                            w_sdaOe = 1'b1;
                            w_state = ADDR_ACK;
                        end else begin
                            w_state = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_sclFall) begin
                        w_bitCnt = '0;
                        if (r_shift[0]) begin
                            w_txReq   = 1'b1;
                            w_txShift = tx_data;
                            w_sdaOe   = ~tx_data[7];
                            w_state   = READ;
                        end else begin
                            w_sdaOe     = 1'b0;
                            w_rxPending = 1'b1;
                            w_state     = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (w_sclRise) begin
                        w_shift  = {r_shift[6:0], r_sdaFilt};
                        w_bitCnt = r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            w_rxData    = {r_shift[6:0], r_sdaFilt};
                            w_rxValid   = 1'b1;
                            w_rxFirst   = r_rxPending;
                            w_rxPending = 1'b0;
                            w_byteDone  = 1'b1;
                        end
                    end else if (w_sclFall && r_byteDone) begin
                        w_byteDone = 1'b0;
                        w_sdaOe    = 1'b1;
                        w_state    = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (w_sclFall) begin
                        w_sdaOe  = 1'b0;
                        w_bitCnt = '0;
                        w_state  = WRITE;
                    end
                end
                READ: begin
                    if (w_sclFall) begin
                        if (r_bitCnt == 3'd7) begin
                            w_sdaOe  = 1'b0;
                            w_bitCnt = '0;
                            w_state  = READ_ACK;
                        end else begin
                            w_txShift = {r_txShift[6:0], 1'b0};
                            w_sdaOe   = ~r_txShift[6];
                            w_bitCnt  = r_bitCnt + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (w_sclRise && r_sdaFilt) begin
                        w_sdaOe = 1'b0;
                        w_state = IGNORE;
                    end else if (w_sclFall) begin
                        w_txReq   = 1'b1;
                        w_txShift = tx_data;
                        w_sdaOe   = ~tx_data[7];
                        w_bitCnt  = '0;
                        w_state   = READ;
                    end
                end
                IGNORE: begin
                    w_sdaOe = 1'b0;
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    assign sda_oe   = r_sdaOe;
    assign rx_data  = r_rxData;
    assign rx_valid = r_rxValid;
    assign rx_first = r_rxFirst;
    assign tx_req   = w_txReq;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: the bench plays the bus initiator on a
// wired-AND SDA and checks acks, delivered bytes, read data and flags.
module tb_i2c_target;

    localparam int H = 40;

    logic       ref_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scl     = 1'b1;
    logic       sdaDrv  = 1'b1;
    logic       sdaBus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;

    int assertCount = 0;
    int failCount   = 0;

    int   rxCount    = 0;
    int   oeCount    = 0;
    int   txReqCount = 0;
    int   busyDrops  = 0;
    logic watchBusy  = 1'b0;
    logic [7:0] rxByteLog  [0:31];
    logic       rxFirstLog [0:31];

    assign sdaBus = sdaDrv & ~sda_oe;

    i2c_target #(.TARGET_ADDR(7'h42), .FILTER_LEN(3)) dut (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .scl_in  (scl),
        .sda_in  (sdaBus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_first(rx_first),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    always #5 ref_clk = ~ref_clk;

    // Event monitor sampling DUT outputs away from the active edge.
    always @(negedge ref_clk) begin
        if (rx_valid) begin
            rxByteLog[rxCount[4:0]]  <= rx_data;
            rxFirstLog[rxCount[4:0]] <= rx_first;
            rxCount <= rxCount + 1;
        end
        if (sda_oe) oeCount <= oeCount + 1;
        if (tx_req) txReqCount <= txReqCount + 1;
        if (watchBusy && !busy) busyDrops <= busyDrops + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge ref_clk);
    endtask

    // One SCL clock from SCL low: set SDA mid-low, sample mid-high, end low.
    task automatic applyStimulus(input logic b, input logic glitch, output logic sampled);
        waitCycles(H / 2);
        sdaDrv = b;
        waitCycles(H / 2);
        scl = 1'b1;
        waitCycles(10);
        if (glitch) begin
            sdaDrv = ~b;
            waitCycles(2);
            sdaDrv = b;
            waitCycles(H / 2 - 12);
        end else begin
            waitCycles(H / 2 - 10);
        end
        sampled = sdaBus;
        waitCycles(H / 2);
        scl = 1'b0;
    endtask

    task automatic busStart();
        sdaDrv = 1'b0;
        waitCycles(H);
        scl = 1'b0;
    endtask

    task automatic busRepStart();
        waitCycles(H / 2);
        sdaDrv = 1'b1;
        waitCycles(H / 2);
        scl = 1'b1;
        waitCycles(H / 2);
        sdaDrv = 1'b0;
        waitCycles(H / 2);
        scl = 1'b0;
    endtask

    task automatic busStop();
        waitCycles(H / 2);
        sdaDrv = 1'b0;
        waitCycles(H / 2);
        scl = 1'b1;
        waitCycles(H / 2);
        sdaDrv = 1'b1;
        waitCycles(H);
    endtask

    task automatic sendByte(input logic [7:0] d, input logic [7:0] glitchMask, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) applyStimulus(d[i], glitchMask[i], s);
        applyStimulus(1'b1, 1'b0, ack);
    endtask

    task automatic readByte(output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, s);
            d = {d[6:0], s};
        end
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;
        int rxBase, oeBase, txBase;

        $display("[TB] reset state");
        waitCycles(5);
        checkOutput("reset_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_rx_first", 32'(rx_first), 32'd0);
        checkOutput("reset_tx_req", 32'(tx_req), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        waitCycles(20);

        $display("[TB] write 0x42: A5 3C");
        rxBase = rxCount;
        busStart();
        checkOutput("w1_busy_after_start", 32'(busy), 32'd1);
        sendByte(8'h84, 8'h00, ack);
        checkOutput("w1_addr_ack", 32'(ack), 32'd0);
        sendByte(8'hA5, 8'h00, ack);
        checkOutput("w1_data0_ack", 32'(ack), 32'd0);
        sendByte(8'h3C, 8'h00, ack);
        checkOutput("w1_data1_ack", 32'(ack), 32'd0);
        checkOutput("w1_busy_before_stop", 32'(busy), 32'd1);
        busStop();
        checkOutput("w1_busy_after_stop", 32'(busy), 32'd0);
        checkOutput("w1_rx_count", 32'(rxCount - rxBase), 32'd2);
        checkOutput("w1_rx0_data", 32'(rxByteLog[rxBase]), 32'hA5);
        checkOutput("w1_rx0_first", 32'(rxFirstLog[rxBase]), 32'd1);
        checkOutput("w1_rx1_data", 32'(rxByteLog[rxBase + 1]), 32'h3C);
        checkOutput("w1_rx1_first", 32'(rxFirstLog[rxBase + 1]), 32'd0);

        $display("[TB] read 0x42: 96 ack, 0F nack");
        txBase = txReqCount;
        tx_data = 8'h96;
        busStart();
        sendByte(8'h85, 8'h00, ack);
        checkOutput("r1_addr_ack", 32'(ack), 32'd0);
        readByte(rd);
        checkOutput("r1_byte0", 32'(rd), 32'h96);
        tx_data = 8'h0F;
        applyStimulus(1'b0, 1'b0, s);
        readByte(rd);
        checkOutput("r1_byte1", 32'(rd), 32'h0F);
        applyStimulus(1'b1, 1'b0, s);
        waitCycles(15);
        checkOutput("r1_oe_after_nack", 32'(sda_oe), 32'd0);
        busStop();
        checkOutput("r1_tx_req_count", 32'(txReqCount - txBase), 32'd2);

        $display("[TB] wrong address 0x43");
        rxBase = rxCount;
        oeBase = oeCount;
        busStart();
        sendByte(8'h86, 8'h00, ack);
        checkOutput("na_addr_nack", 32'(ack), 32'd1);
        sendByte(8'hFF, 8'h00, ack);
        checkOutput("na_data_nack", 32'(ack), 32'd1);
        busStop();
        checkOutput("na_oe_cycles", 32'(oeCount - oeBase), 32'd0);
        checkOutput("na_rx_count", 32'(rxCount - rxBase), 32'd0);

        $display("[TB] write 11, repeated start, read 80");
        rxBase = rxCount;
        txBase = txReqCount;
        tx_data = 8'h80;
        busStart();
        watchBusy = 1'b1;
        sendByte(8'h84, 8'h00, ack);
        checkOutput("rs_waddr_ack", 32'(ack), 32'd0);
        sendByte(8'h11, 8'h00, ack);
        checkOutput("rs_wdata_ack", 32'(ack), 32'd0);
        busRepStart();
        sendByte(8'h85, 8'h00, ack);
        checkOutput("rs_raddr_ack", 32'(ack), 32'd0);
        readByte(rd);
        checkOutput("rs_read_byte", 32'(rd), 32'h80);
        applyStimulus(1'b1, 1'b0, s);
        watchBusy = 1'b0;
        busStop();
        checkOutput("rs_busy_drops", 32'(busyDrops), 32'd0);
        checkOutput("rs_rx_count", 32'(rxCount - rxBase), 32'd1);
        checkOutput("rs_rx_data", 32'(rxByteLog[rxBase]), 32'h11);
        checkOutput("rs_rx_first", 32'(rxFirstLog[rxBase]), 32'd1);
        checkOutput("rs_tx_req_count", 32'(txReqCount - txBase), 32'd1);

        $display("[TB] glitch rejection");
        sdaDrv = 1'b0;
        waitCycles(2);
        sdaDrv = 1'b1;
        waitCycles(20);
        checkOutput("gl_idle_busy", 32'(busy), 32'd0);
        rxBase = rxCount;
        busStart();
        sendByte(8'h84, 8'h00, ack);
        checkOutput("gl_addr_ack", 32'(ack), 32'd0);
        sendByte(8'hF0, 8'h80, ack);
        checkOutput("gl_data_ack", 32'(ack), 32'd0);
        busStop();
        checkOutput("gl_rx_count", 32'(rxCount - rxBase), 32'd1);
        checkOutput("gl_rx_data", 32'(rxByteLog[rxBase]), 32'hF0);

        $display("[TB] reset during address ack");
        busStart();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            a = 8'h84;
            applyStimulus(a[i], 1'b0, s);
        end
        waitCycles(H / 2);
        checkOutput("rst_oe_before", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_oe_async", 32'(sda_oe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("rst_tx_req", 32'(tx_req), 32'd0);
        waitCycles(1);
        scl = 1'b1;
        sdaDrv = 1'b1;
        waitCycles(10);
        rst_n = 1'b1;
        waitCycles(20);
        rxBase = rxCount;
        busStart();
        sendByte(8'h84, 8'h00, ack);
        checkOutput("post_addr_ack", 32'(ack), 32'd0);
        sendByte(8'h5A, 8'h00, ack);
        checkOutput("post_data_ack", 32'(ack), 32'd0);
        busStop();
        checkOutput("post_rx_count", 32'(rxCount - rxBase), 32'd1);
        checkOutput("post_rx_data", 32'(rxByteLog[rxBase]), 32'h5A);
        checkOutput("post_rx_first", 32'(rxFirstLog[rxBase]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
